// File: rtl/memory_pair_scoreboard.sv
// memory_pair_scoreboard: multi-player pair counter for the memory-card game.
// Tracks per-player scores, rotates turns on miss or turn timeout, and reports
// end of game together with the winner and tie indication.
module memory_pair_scoreboard #(
    parameter int NUM_PLAYERS  = 2,
    parameter int TOTAL_PAIRS  = 9,
    parameter int TURN_TIMEOUT = 0,
    parameter int CNT_W        = $clog2(TOTAL_PAIRS + 1),
    parameter int PW           = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         match,
    input  logic                         miss,
    output logic [NUM_PLAYERS*CNT_W-1:0] scores,
    output logic [CNT_W-1:0]             total,
    output logic [PW-1:0]                cur_player,
    output logic                         playing,
    output logic                         game_over,
    output logic [PW-1:0]                winner,
    output logic                         tie
);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR   = CNT_W'(TOTAL_PAIRS - 1);
    localparam logic [PW-1:0]    LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [TW-1:0]    LAST_TICK   = TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           nextState;
    logic [TW-1:0]    idleCnt;
    logic [PW-1:0]    nextPlayer;
    logic             timeoutHit;
    logic [CNT_W-1:0] bestScore;
    logic [PW-1:0]    bestIdx;
    logic [3:0]       nAtBest;

    // Turn-advance helpers: wrapping successor and timeout expiry.
    always_comb begin
        nextPlayer = (cur_player == LAST_PLAYER) ? '0 : cur_player + PW'(1);
        timeoutHit = (TURN_TIMEOUT > 0) && (idleCnt == LAST_TICK);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; start always wins over match in the same cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = PLAY;
            PLAY: if (!start && match && total == LAST_PAIR) nextState = DONE;
            DONE: if (start) nextState = PLAY;
            default: nextState = IDLE;
        endcase
    end

    // Score, total, turn and timeout datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scores     <= '0;
            total      <= '0;
            cur_player <= '0;
            idleCnt    <= '0;
        end else if (start) begin
            scores     <= '0;
            total      <= '0;
            cur_player <= '0;
            idleCnt    <= '0;
        end else if (state == PLAY) begin
            if (match) begin
                scores[cur_player*CNT_W +: CNT_W] <= scores[cur_player*CNT_W +: CNT_W] + CNT_W'(1);
                total   <= total + CNT_W'(1);
                idleCnt <= '0;
            end else if (miss || timeoutHit) begin
                cur_player <= nextPlayer;
                idleCnt    <= '0;
            end else if (TURN_TIMEOUT > 0) begin
                idleCnt <= idleCnt + TW'(1);
            end
        end
    end

    // Output decode: state flags, and winner/tie from the final scores.
    // Strict '>' keeps the lowest index among players sharing the maximum.
    always_comb begin
        playing   = (state == PLAY);
        game_over = (state == DONE);
        bestScore = '0;
        bestIdx   = '0;
        nAtBest   = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (scores[p*CNT_W +: CNT_W] > bestScore) begin
                bestScore = scores[p*CNT_W +: CNT_W];
                bestIdx   = PW'(p);
            end
        end
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (scores[p*CNT_W +: CNT_W] == bestScore) begin
                nAtBest = nAtBest + 4'd1;
            end
        end
        winner = game_over ? bestIdx : '0;
        tie    = game_over && (nAtBest > 4'd1);
    end

endmodule

// File: tb/tb_memory_pair_scoreboard.sv
// Testbench for memory_pair_scoreboard: three configurations run side by side,
// a game-rule reference model predicts each cycle's outputs into a queue and
// a monitor pops and compares them after every rising edge.
module tb_memory_pair_scoreboard;

    localparam int NP0 = 3, TP0 = 9, TO0 = 5;
    localparam int NP1 = 2, TP1 = 4, TO1 = 0;
    localparam int NP2 = 1, TP2 = 9, TO2 = 0;
    localparam int PH_IDLE = 0, PH_PLAY = 1, PH_DONE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] st  = '0;
    logic [2:0] ma  = '0;
    logic [2:0] mi  = '0;

    logic [11:0] scores0;  logic [3:0] total0;  logic [1:0] cur0;  logic [1:0] win0;
    logic [5:0]  scores1;  logic [2:0] total1;  logic       cur1;  logic       win1;
    logic [3:0]  scores2;  logic [3:0] total2;  logic       cur2;  logic       win2;
    logic playing0, over0, tie0, playing1, over1, tie1, playing2, over2, tie2;

    memory_pair_scoreboard #(.NUM_PLAYERS(NP0), .TOTAL_PAIRS(TP0), .TURN_TIMEOUT(TO0)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .match(ma[0]), .miss(mi[0]),
        .scores(scores0), .total(total0), .cur_player(cur0), .playing(playing0),
        .game_over(over0), .winner(win0), .tie(tie0));

    memory_pair_scoreboard #(.NUM_PLAYERS(NP1), .TOTAL_PAIRS(TP1), .TURN_TIMEOUT(TO1)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .match(ma[1]), .miss(mi[1]),
        .scores(scores1), .total(total1), .cur_player(cur1), .playing(playing1),
        .game_over(over1), .winner(win1), .tie(tie1));

    memory_pair_scoreboard #(.NUM_PLAYERS(NP2), .TOTAL_PAIRS(TP2), .TURN_TIMEOUT(TO2)) dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .match(ma[2]), .miss(mi[2]),
        .scores(scores2), .total(total2), .cur_player(cur2), .playing(playing2),
        .game_over(over2), .winner(win2), .tie(tie2));

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        int          total;
        int          cur;
        bit          playing;
        bit          over;
        int          winner;
        bit          tie;
        logic [23:0] sc;
    } exp_t;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatch = 0;

    int mPhase[3];
    int mTotal[3];
    int mCur[3];
    int mIdle[3];
    int mScore[3][3];

    function automatic int npOf(input int k);
        return (k == 0) ? NP0 : (k == 1) ? NP1 : NP2;
    endfunction
    function automatic int tpOf(input int k);
        return (k == 0) ? TP0 : (k == 1) ? TP1 : TP2;
    endfunction
    function automatic int toOf(input int k);
        return (k == 0) ? TO0 : (k == 1) ? TO1 : TO2;
    endfunction

    task automatic modelClear(input int k);
        mTotal[k] = 0;
        mCur[k]   = 0;
        mIdle[k]  = 0;
        for (int p = 0; p < 3; p++) mScore[k][p] = 0;
    endtask

    // Game rules: start restarts; match scores and keeps the turn; miss or
    // TURN_TIMEOUT consecutive idle cycles hands the turn on.
    task automatic modelStep(input int k, input bit s, input bit m, input bit x);
        if (s) begin
            modelClear(k);
            mPhase[k] = PH_PLAY;
        end else if (mPhase[k] == PH_PLAY) begin
            if (m) begin
                mScore[k][mCur[k]]++;
                mTotal[k]++;
                mIdle[k] = 0;
                if (mTotal[k] == tpOf(k)) mPhase[k] = PH_DONE;
            end else if (x) begin
                mCur[k]  = (mCur[k] + 1) % npOf(k);
                mIdle[k] = 0;
            end else if (toOf(k) > 0) begin
                mIdle[k]++;
                if (mIdle[k] == toOf(k)) begin
                    mCur[k]  = (mCur[k] + 1) % npOf(k);
                    mIdle[k] = 0;
                end
            end
        end
    endtask

    function automatic exp_t modelOut(input int k);
        exp_t e;
        int best = -1;
        int w    = 0;
        int cnt  = 0;
        e.inst    = k;
        e.total   = mTotal[k];
        e.cur     = mCur[k];
        e.playing = (mPhase[k] == PH_PLAY);
        e.over    = (mPhase[k] == PH_DONE);
        e.sc      = '0;
        for (int p = 0; p < npOf(k); p++) begin
            e.sc[p*8 +: 8] = 8'(mScore[k][p]);
            if (mScore[k][p] > best) begin
                best = mScore[k][p];
                w    = p;
            end
        end
        for (int p = 0; p < npOf(k); p++) if (mScore[k][p] == best) cnt++;
        e.winner = e.over ? w : 0;
        e.tie    = e.over && (cnt > 1);
        return e;
    endfunction

    function automatic exp_t actualOf(input int k);
        exp_t a;
        a.inst = k;
        a.sc   = '0;
        case (k)
            0: begin
                a.total = int'(total0); a.cur = int'(cur0); a.playing = playing0;
                a.over = over0; a.winner = int'(win0); a.tie = tie0;
                a.sc[7:0]   = {4'b0, scores0[3:0]};
                a.sc[15:8]  = {4'b0, scores0[7:4]};
                a.sc[23:16] = {4'b0, scores0[11:8]};
            end
            1: begin
                a.total = int'(total1); a.cur = int'(cur1); a.playing = playing1;
                a.over = over1; a.winner = int'(win1); a.tie = tie1;
                a.sc[7:0]  = {5'b0, scores1[2:0]};
                a.sc[15:8] = {5'b0, scores1[5:3]};
            end
            default: begin
                a.total = int'(total2); a.cur = int'(cur2); a.playing = playing2;
                a.over = over2; a.winner = int'(win2); a.tie = tie2;
                a.sc[7:0] = {4'b0, scores2};
            end
        endcase
        return a;
    endfunction

    task automatic chk(input string name, input int k, input int act, input int req);
        nCompared++;
        if (act != req) begin
            nMismatch++;
            $display("FAIL %s inst=%0d t=%0t actual=%0d required=%0d", name, k, $time, act, req);
        end
    endtask

    task automatic compareOne(input exp_t e);
        exp_t a;
        a = actualOf(e.inst);
        chk("total", e.inst, a.total, e.total);
        chk("cur_player", e.inst, a.cur, e.cur);
        chk("playing", e.inst, int'(a.playing), int'(e.playing));
        chk("game_over", e.inst, int'(a.over), int'(e.over));
        chk("winner", e.inst, a.winner, e.winner);
        chk("tie", e.inst, int'(a.tie), int'(e.tie));
        for (int p = 0; p < npOf(e.inst); p++)
            chk($sformatf("score[%0d]", p), e.inst, int'(a.sc[p*8 +: 8]), int'(e.sc[p*8 +: 8]));
    endtask

    // Monitor: every rising edge, check all predictions queued for it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                compareOne(e);
            end
        end
    end

    // One clock of stimulus: drive inputs at the falling edge and queue the
    // model's prediction for the following rising edge.
    task automatic cycle(input logic r, input logic [2:0] s, input logic [2:0] m, input logic [2:0] x);
        @(negedge clk);
        rst = r; st = s; ma = m; mi = x;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                modelClear(k);
                mPhase[k] = PH_IDLE;
            end else begin
                modelStep(k, s[k], m[k], x[k]);
            end
            expQ.push_back(modelOut(k));
        end
    endtask

    // Raise rst between edges and check that outputs clear without a clock.
    task automatic asyncResetCheck();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            modelClear(k);
            mPhase[k] = PH_IDLE;
            compareOne(modelOut(k));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            modelClear(k);
            mPhase[k] = PH_IDLE;
        end

        repeat (3) cycle(1, 3'b000, 3'b000, 3'b000);
        // matches with no start are ignored
        repeat (3) begin
            cycle(0, 3'b000, 3'b111, 3'b000);
            cycle(0, 3'b000, 3'b000, 3'b000);
        end

        // single player: nine gapped/contiguous matches, misses, then overruns
        cycle(0, 3'b100, 3'b000, 3'b000);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 3'b000, 3'b100, 3'b000);
            if (i % 3 == 1) cycle(0, 3'b000, 3'b000, 3'b100);
            if (i % 4 == 2) cycle(0, 3'b000, 3'b000, 3'b000);
        end
        repeat (3) cycle(0, 3'b000, 3'b100, 3'b000);

        // three players: rotation, match+miss priority, then timeout
        cycle(0, 3'b001, 3'b000, 3'b000);
        repeat (3) cycle(0, 3'b000, 3'b000, 3'b001);
        cycle(0, 3'b000, 3'b001, 3'b001);
        repeat (5) cycle(0, 3'b000, 3'b000, 3'b000);
        repeat (3) cycle(0, 3'b000, 3'b000, 3'b000);
        cycle(0, 3'b000, 3'b001, 3'b000);
        repeat (6) cycle(0, 3'b000, 3'b000, 3'b000);

        // two players, four pairs: tie game, then player 1 wins 3-1
        cycle(0, 3'b010, 3'b000, 3'b000);
        cycle(0, 3'b000, 3'b010, 3'b000);
        cycle(0, 3'b000, 3'b000, 3'b010);
        cycle(0, 3'b000, 3'b010, 3'b000);
        cycle(0, 3'b000, 3'b010, 3'b000);
        cycle(0, 3'b000, 3'b000, 3'b010);
        cycle(0, 3'b000, 3'b010, 3'b000);
        repeat (2) cycle(0, 3'b000, 3'b010, 3'b010);
        cycle(0, 3'b010, 3'b000, 3'b000);
        cycle(0, 3'b000, 3'b000, 3'b010);
        repeat (3) cycle(0, 3'b000, 3'b010, 3'b000);
        cycle(0, 3'b000, 3'b000, 3'b010);
        cycle(0, 3'b000, 3'b010, 3'b000);
        cycle(0, 3'b000, 3'b000, 3'b000);

        // restart mid-game, with a match in the start cycle
        cycle(0, 3'b001, 3'b000, 3'b000);
        repeat (3) cycle(0, 3'b000, 3'b001, 3'b000);
        cycle(0, 3'b001, 3'b001, 3'b000);
        cycle(0, 3'b000, 3'b000, 3'b000);

        // randomized play on all three configurations
        for (int i = 0; i < 600; i++) begin
            logic [2:0] s, m, x;
            for (int k = 0; k < 3; k++) begin
                s[k] = ($urandom_range(0, 39) == 0);
                m[k] = ($urandom_range(0, 2) == 0);
                x[k] = ($urandom_range(0, 3) == 0);
            end
            cycle(0, s, m, x);
        end

        // second game interrupted by an asynchronous reset
        cycle(0, 3'b111, 3'b000, 3'b000);
        repeat (2) cycle(0, 3'b000, 3'b111, 3'b000);
        asyncResetCheck();
        repeat (2) cycle(1, 3'b000, 3'b111, 3'b000);
        cycle(0, 3'b000, 3'b111, 3'b000);
        cycle(0, 3'b111, 3'b000, 3'b000);
        repeat (3) cycle(0, 3'b000, 3'b111, 3'b000);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
